// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU scheduler slice.
//   - opcode constants understood by the shared ALU and the scheduler
//   - ALU_W: datapath width of operands and results
//   - alu_req_t: one requester's operation (opcode + two signed operands)
//   - is_legal_op: true for the opcodes the scheduler executes
package alu_pkg;

    localparam int ALU_W = 11;

    localparam logic [3:0] ALU_ADD = 4'h8;
    localparam logic [3:0] ALU_SUB = 4'h9;
    localparam logic [3:0] ALU_MUL = 4'hA;
    localparam logic [3:0] ALU_NOT = 4'hB;
    localparam logic [3:0] ALU_SGT = 4'hD;
    localparam logic [3:0] ALU_SLT = 4'hE;

    typedef struct packed {
        logic [3:0]              funct;
        logic signed [ALU_W-1:0] in0;
        logic signed [ALU_W-1:0] in1;
    } alu_req_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_ADD, ALU_SUB, ALU_MUL, ALU_NOT, ALU_SGT, ALU_SLT: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: shared combinational datapath.
//   funct          opcode
//   in0, in1       signed operands
//   out            signed result (low ALU_W bits); SGT/SLT and unknown opcodes give 0
//   overflow       result did not fit in ALU_W signed bits (ADD/SUB/MUL only)
//   gr, le, eq     signed comparison of in0 against in1, for every opcode
module alu
    import alu_pkg::*;
(
    input  logic [3:0]              funct,
    input  logic signed [ALU_W-1:0] in0,
    input  logic signed [ALU_W-1:0] in1,
    output logic signed [ALU_W-1:0] out,
    output logic                    overflow,
    output logic                    gr,
    output logic                    le,
    output logic                    eq
);

    // One extra bit for sum/difference, double width for the product;
    // a result fits when every bit above the kept sign bit equals it.
    logic [ALU_W:0]     sum_s;
    logic [ALU_W:0]     diff_s;
    logic [2*ALU_W-1:0] prod_s;

    assign sum_s  = {in0[ALU_W-1], in0} + {in1[ALU_W-1], in1};
    assign diff_s = {in0[ALU_W-1], in0} - {in1[ALU_W-1], in1};
    // Low 2*ALU_W bits of the product are identical for signed and unsigned
    // interpretation once both operands are sign-extended.
    assign prod_s = {{ALU_W{in0[ALU_W-1]}}, in0} * {{ALU_W{in1[ALU_W-1]}}, in1};

    assign gr = (in0 > in1);
    assign le = (in0 < in1);
    assign eq = (in0 == in1);

    // Opcode decode into result and overflow.
    always_comb begin
        out      = {ALU_W{1'b0}};
        overflow = 1'b0;
        case (funct)
            ALU_ADD: begin
                out      = sum_s[ALU_W-1:0];
                overflow = sum_s[ALU_W] ^ sum_s[ALU_W-1];
            end
            ALU_SUB: begin
                out      = diff_s[ALU_W-1:0];
                overflow = diff_s[ALU_W] ^ diff_s[ALU_W-1];
            end
            ALU_MUL: begin
                out      = prod_s[ALU_W-1:0];
                overflow = (prod_s[2*ALU_W-1:ALU_W-1] != {(ALU_W+1){prod_s[ALU_W-1]}});
            end
            ALU_NOT: begin
                out      = (in0 == {ALU_W{1'b0}}) ? 11'sd127 : {ALU_W{1'b0}};
                overflow = 1'b0;
            end
            default: begin
                out      = {ALU_W{1'b0}};
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant over NREQ requesters.
//   clk, reset     clock, asynchronous active-high reset
//   req_valid      per-requester valid
//   grant          one-hot grant (combinational), only on valid requesters
//   grant_valid    some requester is granted this cycle (a transfer happens)
//   grant_idx      index of the granted requester
// The pointer names the highest-priority requester and moves to one past
// the granted requester after every transfer.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    int             scan_idx_s;

    // Scan from the pointer upward (wrapping) and grant the first valid.
    always_comb begin
        grant       = {NREQ{1'b0}};
        grant_valid = 1'b0;
        grant_idx   = {IDW{1'b0}};
        scan_idx_s  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_valid && req_valid[scan_idx_s]) begin
                grant[scan_idx_s] = 1'b1;
                grant_valid       = 1'b1;
                grant_idx         = IDW'(scan_idx_s);
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

    // Next pointer: one past the winner on a transfer, otherwise hold.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            if (grant_idx == IDW'(NREQ - 1)) begin
                rr_ptr_d = {IDW{1'b0}};
            end else begin
                rr_ptr_d = grant_idx + IDW'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= {IDW{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one ALU between NREQ requesters.
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      per-requester valid and one-hot grant
//   req_funct                  packed opcodes, requester i at [4i+3:4i]
//   req_in0, req_in1           packed signed operands, requester i at [11i+10:11i]
//   resp_valid                 one-cycle pulse per accepted request, 2 clocks after transfer
//   resp_id                    owner of the result
//   resp_out, resp_overflow    result and overflow
//   resp_gr/le/eq              signed comparison flags of the operands
//   resp_illegal               opcode was not executable
// Pipeline: grant -> stage-1 issue register -> ALU -> response register.
// There is no backpressure, so both stages advance every cycle.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [4*NREQ-1:0]       req_funct,
    input  logic [ALU_W*NREQ-1:0]   req_in0,
    input  logic [ALU_W*NREQ-1:0]   req_in1,
    output logic                    resp_valid,
    output logic [IDW-1:0]          resp_id,
    output logic signed [ALU_W-1:0] resp_out,
    output logic                    resp_overflow,
    output logic                    resp_gr,
    output logic                    resp_le,
    output logic                    resp_eq,
    output logic                    resp_illegal
);

    logic                    grant_valid_s;
    logic [IDW-1:0]          grant_idx_s;

    logic                    s1_valid_q, s1_valid_d;
    alu_req_t                s1_req_q,   s1_req_d;
    logic [IDW-1:0]          s1_id_q,    s1_id_d;

    logic signed [ALU_W-1:0] alu_out_s;
    logic                    alu_ov_s, alu_gr_s, alu_le_s, alu_eq_s;

    logic                    resp_valid_q,    resp_valid_d;
    logic [IDW-1:0]          resp_id_q,       resp_id_d;
    logic signed [ALU_W-1:0] resp_out_q,      resp_out_d;
    logic                    resp_overflow_q, resp_overflow_d;
    logic                    resp_gr_q,       resp_gr_d;
    logic                    resp_le_q,       resp_le_d;
    logic                    resp_eq_q,       resp_eq_d;
    logic                    resp_illegal_q,  resp_illegal_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .grant       (req_ready),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Stage 1: capture the granted requester's payload; payload holds when idle.
    always_comb begin
        s1_valid_d = 1'b0;
        s1_req_d   = s1_req_q;
        s1_id_d    = s1_id_q;
        if (grant_valid_s) begin
            s1_valid_d     = 1'b1;
            s1_req_d.funct = req_funct[4*int'(grant_idx_s) +: 4];
            s1_req_d.in0   = req_in0[ALU_W*int'(grant_idx_s) +: ALU_W];
            s1_req_d.in1   = req_in1[ALU_W*int'(grant_idx_s) +: ALU_W];
            s1_id_d        = grant_idx_s;
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s1_id_q    <= {IDW{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s1_id_q    <= s1_id_d;
        end
    end

    alu u_alu (
        .funct    (s1_req_q.funct),
        .in0      (s1_req_q.in0),
        .in1      (s1_req_q.in1),
        .out      (alu_out_s),
        .overflow (alu_ov_s),
        .gr       (alu_gr_s),
        .le       (alu_le_s),
        .eq       (alu_eq_s)
    );

    // Stage 2: map ALU outputs to the response; SGT/SLT are built from the
    // ALU flags because the ALU itself returns 0 for them.
    always_comb begin
        resp_valid_d    = s1_valid_q;
        resp_id_d       = resp_id_q;
        resp_out_d      = resp_out_q;
        resp_overflow_d = resp_overflow_q;
        resp_gr_d       = resp_gr_q;
        resp_le_d       = resp_le_q;
        resp_eq_d       = resp_eq_q;
        resp_illegal_d  = resp_illegal_q;
        if (s1_valid_q) begin
            resp_id_d      = s1_id_q;
            resp_gr_d      = alu_gr_s;
            resp_le_d      = alu_le_s;
            resp_eq_d      = alu_eq_s;
            resp_illegal_d = !is_legal_op(s1_req_q.funct);
            case (s1_req_q.funct)
                ALU_ADD, ALU_SUB, ALU_MUL, ALU_NOT: begin
                    resp_out_d      = alu_out_s;
                    resp_overflow_d = alu_ov_s;
                end
                ALU_SGT: begin
                    resp_out_d      = alu_gr_s ? 11'sd1 : 11'sd0;
                    resp_overflow_d = 1'b0;
                end
                ALU_SLT: begin
                    resp_out_d      = alu_le_s ? 11'sd1 : 11'sd0;
                    resp_overflow_d = 1'b0;
                end
                default: begin
                    resp_out_d      = 11'sd0;
                    resp_overflow_d = 1'b0;
                end
            endcase
        end else begin
            resp_valid_d = 1'b0;
        end
    end

    // Response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q    <= 1'b0;
            resp_id_q       <= {IDW{1'b0}};
            resp_out_q      <= 11'sd0;
            resp_overflow_q <= 1'b0;
            resp_gr_q       <= 1'b0;
            resp_le_q       <= 1'b0;
            resp_eq_q       <= 1'b0;
            resp_illegal_q  <= 1'b0;
        end else begin
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_out_q      <= resp_out_d;
            resp_overflow_q <= resp_overflow_d;
            resp_gr_q       <= resp_gr_d;
            resp_le_q       <= resp_le_d;
            resp_eq_q       <= resp_eq_d;
            resp_illegal_q  <= resp_illegal_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_out      = resp_out_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_gr       = resp_gr_q;
    assign resp_le       = resp_le_q;
    assign resp_eq       = resp_eq_q;
    assign resp_illegal  = resp_illegal_q;

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares one `alu` datapath between `NREQ` requesting microcontroller cores, using round-robin arbitration. Each requester presents an opcode and two signed 11-bit operands on a valid/ready channel. The block registers the granted operation, evaluates it on the shared ALU, and returns a registered, tagged result with overflow and comparison flags. It also implements the SLT/SGT opcodes, which the ALU itself leaves at zero, from the ALU flag outputs.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters; legal range 2..4.
- `IDW`, default 2: requester-ID width; must satisfy 2^IDW >= NREQ.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot grant; a request transfers when `req_valid[i] & req_ready[i]`.
- `req_funct`  in  4*NREQ  packed opcodes; requester i uses bits [4i+3:4i].
- `req_in0`  in  11*NREQ  packed signed operand A.
- `req_in1`  in  11*NREQ  packed signed operand B.
- `resp_valid`  out  1  result valid; single-cycle pulse per accepted request.
- `resp_id`  out  IDW  index of the requester that owns the result.
- `resp_out`  out  11  signed result.
- `resp_overflow`  out  1  ALU overflow for ADD/SUB/MUL; 0 for all other opcodes.
- `resp_gr`, `resp_le`, `resp_eq`  out  1 each  comparison flags: in0>in1, in0<in1, in0==in1, all signed.
- `resp_illegal`  out  1  the opcode was not one of ADD(8), SUB(9), MUL(10), NOT(11), SGT(13), SLT(14).

## Operation
- Arbitration:
  - The round-robin pointer `rr_ptr` (IDW bits) names the highest-priority requester.
  - The grant goes to the first `req_valid[i]` found scanning i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - `req_ready` is combinational from `req_valid` and `rr_ptr`. At most one bit is set, and never a bit whose `req_valid` is 0.
  - The block has no backpressure: the pipeline always advances, so throughput is one request per cycle.
- Pointer update: on a transfer from requester g, `rr_ptr <= (g+1) mod NREQ`. With no transfer, `rr_ptr` holds.
- Stage 1 (issue register): on a transfer, capture funct, in0, in1, the requester ID, and `s1_valid=1`. With no transfer, `s1_valid <= 0` and the payload holds.
- Stage 2 (ALU plus response register):
  - The ALU is driven from stage-1 registers.
  - `resp_*` is registered from the ALU outputs and `s1_valid`.
- Result mapping:
  - ADD, SUB, MUL, NOT: `resp_out`/`resp_overflow` come straight from the ALU. MUL keeps the low 11 bits, and overflow is set when the full product does not fit in 11 signed bits. NOT returns 127 if in0==0, else 0.
  - SGT: `resp_out = gr_flag ? 1 : 0`.
  - SLT: `resp_out = le_flag ? 1 : 0`.
  - SGT/SLT and illegal opcodes: `resp_overflow = 0`.
  - Illegal opcodes: `resp_out = 0`, `resp_illegal = 1`.
- Flags: `resp_gr/le/eq` are always driven from the operands, for every opcode including illegal ones.
- When `resp_valid=0`, `resp_out`, flags and ID hold their last values; the bench must not check them.
- Requesters must hold valid and payload stable until `ready`. The block is not required to handle payload changes while a request waits.

## Timing
- Latency: a request transferred at edge N produces `resp_valid=1` in the cycle after edge N+1, i.e. 2 clocks.
- The response stream preserves grant order.
- Back-to-back: grants on consecutive cycles give `resp_valid` on consecutive cycles.
- Reset values: `rr_ptr=0`, `s1_valid=0`, `resp_valid=0`, `resp_id=0`, `resp_out=0`, all flags 0, `resp_overflow=0`, `resp_illegal=0`.
- Reset mid-operation: in-flight stage-1 and stage-2 operations are discarded. No `resp_valid` is produced for them after reset deasserts.
- During reset, `req_ready` may be nonzero combinationally, but no transfer is recorded.
- Simultaneous requests: only one requester is served per cycle. The others wait at most NREQ-1 cycles while held valid.

## Structure
- Package `alu_pkg` holds:
  - opcode constants `ALU_ADD=4'h8`, `ALU_SUB=4'h9`, `ALU_MUL=4'hA`, `ALU_NOT=4'hB`, `ALU_SGT=4'hD`, `ALU_SLT=4'hE`;
  - `ALU_W=11`;
  - a `alu_req_t` struct {funct, in0, in1}.
- Sub-module `rr_arbiter` (parameter NREQ): combinational grant computation plus the pointer register.
- The existing `alu` is instantiated once inside this block.

## Test plan
- Single ADD: req0 sends ADD 5,7 → `resp_valid` 2 cycles later, id=0, out=12, ov=0, le=1.
- Overflow: req1 sends ADD 1000,100 → out=-948, ov=1. MUL 40,40 → ov=1.
- Compare: SLT -3,2 → out=1. SGT -3,2 → out=0, le=1, eq=0. NOT 0 → 127. Opcode 4'h0 → out=0, illegal=1.
- Contention: NREQ=2, both valid held for 4 cycles → grants alternate 0,1,0,1; 4 consecutive responses with ids 0,1,0,1.
- Reset mid-flight: assert reset one cycle after a grant → no `resp_valid` afterwards and `rr_ptr` back to 0. The first post-reset contention grants requester 0.
- Starvation bound: NREQ=4, all valid continuously for 12 cycles → each requester granted exactly 3 times, in order 0,1,2,3 repeating.
